// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: sync, data-enable, coordinates and strobes.
// Optional frame counter port enabled by defining VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 56,
  parameter int H_SYNC   = 120,
  parameter int H_BP     = 64,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 37,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 23,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int CW       = 11,
  parameter int FCW      = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  output logic          hs,
  output logic          vs,
  output logic          de,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
`ifdef VGA_TIMING_FRAME_CNT_EN
  output logic          frame_start,
  output logic [FCW-1:0] frame_cnt
`else
  output logic          frame_start
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [CW-1:0] x_n, y_n;
  logic          hs_n, vs_n, de_n, ls_n, fs_n;

  // Flags are decoded from the next-state coordinates so that, once
  // registered, they line up with x/y without a cycle of skew.
  always_comb begin
    x_n = x;
    y_n = y;
    if (ce) begin
      if (x == H_LAST) begin
        x_n = '0;
        y_n = (y == V_LAST) ? '0 : y + CW'(1);
      end else begin
        x_n = x + CW'(1);
      end
    end
    hs_n = ((x_n >= HS_BEG) && (x_n <= HS_END)) ? HS_POL : ~HS_POL;
    vs_n = ((y_n >= VS_BEG) && (y_n <= VS_END)) ? VS_POL : ~VS_POL;
    de_n = (x_n < H_ACT) && (y_n < V_ACT);
    ls_n = ce && (x_n == '0);
    fs_n = ce && (x_n == '0) && (y_n == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x           <= H_LAST;
      y           <= V_LAST;
      hs          <= ~HS_POL;
      vs          <= ~VS_POL;
      de          <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      x           <= x_n;
      y           <= y_n;
      hs          <= hs_n;
      vs          <= vs_n;
      de          <= de_n;
      line_start  <= ls_n;
      frame_start <= fs_n;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       frame_cnt <= '0;
    else if (fs_n) frame_cnt <= frame_cnt + FCW'(1);
  end
`else
  logic [FCW-1:0] unused_fcw;
  assign unused_fcw = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: small-mode vector table plus randomized runs
// against a linear pixel-index reference model on three parameter sets.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_v [3];
  logic        ce_v  [3];
  logic        a_hs  [3];
  logic        a_vs  [3];
  logic        a_de  [3];
  logic        a_ls  [3];
  logic        a_fs  [3];
  logic [10:0] a_x   [3];
  logic [10:0] a_y   [3];
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [1:0]  fc0;
  logic [15:0] fc1, fc2;
`endif

  // 0: small mode, 1: defaults, 2: small horizontal with default vertical
  vga_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
                   .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
                   .HS_POL(1'b0), .VS_POL(1'b0), .CW(11), .FCW(2)) u_small (
    .clk(clk), .rst(rst_v[0]), .ce(ce_v[0]), .hs(a_hs[0]), .vs(a_vs[0]),
    .de(a_de[0]), .x(a_x[0]), .y(a_y[0]), .line_start(a_ls[0]),
`ifdef VGA_TIMING_FRAME_CNT_EN
    .frame_cnt(fc0),
`endif
    .frame_start(a_fs[0]));

  vga_timing_gen u_dflt (
    .clk(clk), .rst(rst_v[1]), .ce(ce_v[1]), .hs(a_hs[1]), .vs(a_vs[1]),
    .de(a_de[1]), .x(a_x[1]), .y(a_y[1]), .line_start(a_ls[1]),
`ifdef VGA_TIMING_FRAME_CNT_EN
    .frame_cnt(fc1),
`endif
    .frame_start(a_fs[1]));

  vga_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1)) u_vert (
    .clk(clk), .rst(rst_v[2]), .ce(ce_v[2]), .hs(a_hs[2]), .vs(a_vs[2]),
    .de(a_de[2]), .x(a_x[2]), .y(a_y[2]), .line_start(a_ls[2]),
`ifdef VGA_TIMING_FRAME_CNT_EN
    .frame_cnt(fc2),
`endif
    .frame_start(a_fs[2]));

  int ha[3], hf[3], hsy[3], hb[3], va[3], vf[3], vsy[3], vb[3];
  bit hp[3], vp[3];
  int p[3];
  bit m_ls[3], m_fs[3];
  int fcnt[3];
  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    bit rst, ce;
    int x, y;
    bit hs, vs, de, ls, fs;
  } vec_t;
  vec_t tv[12];

  function automatic int htot(int i); return ha[i] + hf[i] + hsy[i] + hb[i]; endfunction
  function automatic int vtot(int i); return va[i] + vf[i] + vsy[i] + vb[i]; endfunction

  task automatic chk(string nm, int i, longint act, longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s inst%0d got %0d want %0d at t=%0t", nm, i, act, exp, $time);
    end
  endtask

  // Reference: raster position is a single pixel index p in [0, H*V).
  task automatic model_step(int i, bit r, bit c);
    if (r) begin
      p[i] = htot(i) * vtot(i) - 1; m_ls[i] = 0; m_fs[i] = 0; fcnt[i] = 0;
    end else if (c) begin
      p[i] = (p[i] + 1) % (htot(i) * vtot(i));
      m_ls[i] = (p[i] % htot(i)) == 0;
      m_fs[i] = p[i] == 0;
      if (m_fs[i]) fcnt[i]++;
    end else begin
      m_ls[i] = 0; m_fs[i] = 0;
    end
  endtask

  task automatic check_inst(int i);
    int hx, vy;
    hx = p[i] % htot(i);
    vy = p[i] / htot(i);
    chk("x", i, a_x[i], hx);
    chk("y", i, a_y[i], vy);
    chk("hs", i, a_hs[i], (hx >= ha[i] + hf[i] && hx < ha[i] + hf[i] + hsy[i]) ? hp[i] : !hp[i]);
    chk("vs", i, a_vs[i], (vy >= va[i] + vf[i] && vy < va[i] + vf[i] + vsy[i]) ? vp[i] : !vp[i]);
    chk("de", i, a_de[i], (hx < ha[i] && vy < va[i]) ? 1 : 0);
    chk("line_start", i, a_ls[i], m_ls[i]);
    chk("frame_start", i, a_fs[i], m_fs[i]);
`ifdef VGA_TIMING_FRAME_CNT_EN
    if (i == 0) chk("frame_cnt", i, fc0, fcnt[0] % 4);
    if (i == 1) chk("frame_cnt", i, fc1, fcnt[1] % 65536);
    if (i == 2) chk("frame_cnt", i, fc2, fcnt[2] % 65536);
`endif
  endtask

  // mode: 0 ce=1, 1 random ce, 2 toggling ce, 3 random ce with random resets
  task automatic run(int i, int cycles, int mode);
    bit r, c;
    for (int k = 0; k < cycles; k++) begin
      r = 0;
      case (mode)
        0:       c = 1;
        2:       c = (k % 2) == 0;
        default: c = 1'($urandom_range(0, 1));
      endcase
      if (mode == 3) r = ($urandom_range(0, 149) == 0);
      rst_v[i] = r;
      ce_v[i]  = c;
      @(posedge clk); #1;
      model_step(i, r, c);
      check_inst(i);
    end
    rst_v[i] = 0;
    ce_v[i]  = 0;
  endtask

  initial begin
    ha  = '{4, 800, 4};  hf  = '{1, 56, 1};  hsy = '{2, 120, 2}; hb = '{1, 64, 1};
    va  = '{3, 600, 600}; vf = '{1, 37, 37}; vsy = '{1, 6, 6};    vb = '{1, 23, 23};
    hp  = '{0, 1, 1};    vp  = '{0, 1, 1};

    tv[0]  = '{1, 0, 7, 5, 1, 1, 0, 0, 0};
    tv[1]  = '{0, 0, 7, 5, 1, 1, 0, 0, 0};
    tv[2]  = '{0, 1, 0, 0, 1, 1, 1, 1, 1};
    tv[3]  = '{0, 1, 1, 0, 1, 1, 1, 0, 0};
    tv[4]  = '{0, 0, 1, 0, 1, 1, 1, 0, 0};
    tv[5]  = '{0, 1, 2, 0, 1, 1, 1, 0, 0};
    tv[6]  = '{0, 1, 3, 0, 1, 1, 1, 0, 0};
    tv[7]  = '{0, 1, 4, 0, 1, 1, 0, 0, 0};
    tv[8]  = '{0, 1, 5, 0, 0, 1, 0, 0, 0};
    tv[9]  = '{0, 1, 6, 0, 0, 1, 0, 0, 0};
    tv[10] = '{0, 1, 7, 0, 1, 1, 0, 0, 0};
    tv[11] = '{0, 1, 0, 1, 1, 1, 1, 1, 0};

    for (int i = 0; i < 3; i++) begin rst_v[i] = 1; ce_v[i] = 0; end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) model_step(i, 1, 0);
    for (int i = 0; i < 3; i++) check_inst(i);
    for (int i = 0; i < 3; i++) rst_v[i] = 0;

    for (int k = 0; k < 12; k++) begin
      rst_v[0] = tv[k].rst;
      ce_v[0]  = tv[k].ce;
      @(posedge clk); #1;
      chk("tv_x", k, a_x[0], tv[k].x);
      chk("tv_y", k, a_y[0], tv[k].y);
      chk("tv_hs", k, a_hs[0], tv[k].hs);
      chk("tv_vs", k, a_vs[0], tv[k].vs);
      chk("tv_de", k, a_de[0], tv[k].de);
      chk("tv_ls", k, a_ls[0], tv[k].ls);
      chk("tv_fs", k, a_fs[0], tv[k].fs);
    end
    p[0] = 8; m_ls[0] = 1; m_fs[0] = 0; fcnt[0] = 1;

    // Walk to x=3,y=2 then assert reset between clock edges.
    run(0, 11, 0);
    chk("pre_rst_x", 0, a_x[0], 3);
    chk("pre_rst_y", 0, a_y[0], 2);
    #2 rst_v[0] = 1;
    #1;
    chk("async_rst_x", 0, a_x[0], 7);
    chk("async_rst_y", 0, a_y[0], 5);
    chk("async_rst_ls", 0, a_ls[0], 0);
    @(posedge clk); #1;
    rst_v[0] = 0;
    model_step(0, 1, 0);
    check_inst(0);

    run(0, 48 * 5, 0);
    run(0, 200, 2);
    run(0, 2000, 3);

    run(1, 2200, 0);
    run(1, 400, 2);
    run(1, 2000, 1);

    run(2, 666 * 8 * 2 + 50, 0);
    run(2, 2000, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised raster timing generator for the VGA output path. It produces horizontal and vertical sync, a data-enable flag, pixel coordinates and line/frame strobes for any mode described by its parameters. A pixel clock-enable input lets the block run from the system clock. It sits between the clock domain root and the frame-buffer reader / pixel mux, which consume `x`, `y`, `de` and the strobes.

## Interface
Parameters:
- `H_ACTIVE`, 800: visible pixels per line
- `H_FP`, 56: horizontal front porch, in pixels
- `H_SYNC`, 120: horizontal sync width, in pixels
- `H_BP`, 64: horizontal back porch, in pixels
- `V_ACTIVE`, 600: visible lines per frame
- `V_FP`, 37: vertical front porch, in lines
- `V_SYNC`, 6: vertical sync width, in lines
- `V_BP`, 23: vertical back porch, in lines
- `HS_POL`, 1: level of `hs` while the horizontal sync pulse is active
- `VS_POL`, 1: level of `vs` while the vertical sync pulse is active
- `CW`, 11: width of the coordinate counters
- `FCW`, 16: width of the frame counter

Derived values:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 1040)
- V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 666)

Parameter rules:
- All porch and sync parameters must be ≥1.
- `CW` must be wide enough to hold H_TOTAL-1 and V_TOTAL-1.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `ce`  in  1  pixel enable; the raster advances one pixel per rising edge with `ce`=1
- `hs`  out  1  horizontal sync (registered)
- `vs`  out  1  vertical sync (registered)
- `de`  out  1  active-video flag (registered)
- `x`  out  CW  current pixel column
- `y`  out  CW  current line
- `line_start`  out  1  one-clock pulse at x=0
- `frame_start`  out  1  one-clock pulse at x=0, y=0
- `frame_cnt`  out  FCW  frame counter; present only with `VGA_TIMING_FRAME_CNT_EN`

## Operation
- **Reset state:** x=H_TOTAL-1, y=V_TOTAL-1, `hs`=!HS_POL, `vs`=!VS_POL, `de`=0, `line_start`=0, `frame_start`=0, `frame_cnt`=0.
  - This is the last pixel of the back porch, so all outputs are mutually consistent while reset is held.
- **Advance** (each edge with `ce`=1):
  - If x==H_TOTAL-1, x←0; otherwise x←x+1.
  - When x wraps, y advances the same way: if y==V_TOTAL-1, y←0; otherwise y←y+1.
- **Output alignment:** `hs`, `vs`, `de` and the strobes are registered from the next-state x/y. They always describe the x/y currently presented, with zero skew.
- **Output decode:**
  - `hs` = HS_POL when H_ACTIVE+H_FP ≤ x ≤ H_ACTIVE+H_FP+H_SYNC-1; otherwise !HS_POL.
  - `vs` = VS_POL when V_ACTIVE+V_FP ≤ y ≤ V_ACTIVE+V_FP+V_SYNC-1; otherwise !VS_POL. `vs` changes together with x=0 of the line.
  - `de` = 1 when x<H_ACTIVE and y<V_ACTIVE.
  - `line_start` = 1 for the single edge on which x becomes 0.
  - `frame_start` = 1 for the single edge on which x and y both become 0.
- **`ce`=0:** x, y, `hs`, `vs`, `de` hold; `line_start` and `frame_start` are 0 on that cycle.
- **Arithmetic:** coordinate compares are unsigned, in `CW` bits. Counters never exceed H_TOTAL-1 / V_TOTAL-1.

## Timing
- First `ce` after reset release → x=0, y=0, `de`=1, `line_start`=1, `frame_start`=1, all on that edge.
- Line period = H_TOTAL `ce` cycles. Frame period = H_TOTAL×V_TOTAL `ce` cycles (692640 with defaults).
- Strobes are exactly one `clk` wide, even when `ce` is held high.
- Reset asserted mid-frame forces the reset state asynchronously. No strobe is emitted by the reset itself.
- Latency from `ce` edge to coordinate and flag outputs: 0 extra cycles; all are valid after the same edge.

## Configuration
- Macro: `VGA_TIMING_FRAME_CNT_EN`.
- **Defined:**
  - `frame_cnt` port exists.
  - It increments (mod 2^FCW) on every edge where `frame_start`=1, so it reads 1 during the first frame after reset.
  - It wraps from 2^FCW-1 to 0.
- **Undefined:** the port and its register are absent. All other behaviour is identical.

## Test plan
- **Reset state:** defaults, `rst`=1 then release with `ce`=0 → x=1039, y=665, `hs`=0, `vs`=0, `de`=0, no strobes.
- **First edge:** defaults, `ce`=1 continuous → first edge gives x=0, y=0, `de`=1, both strobes high.
  - `de` falls at x=800.
  - `hs`=1 for x=856..975 (120 cycles).
  - `line_start` recurs every 1040 cycles.
- **Vertical timing:** defaults, `ce`=1 for a full frame →
  - `vs`=1 for y=637..642.
  - `de`=0 for all of y≥600.
  - Next `frame_start` 692640 edges after the first.
- **`ce` gating:** defaults, `ce` toggling 1,0 → outputs advance every other clock; strobes last one `clk` and never on a `ce`=0 cycle.
- **Small mode:** H 4/1/2/1, V 3/1/1/1, HS_POL=VS_POL=0 →
  - H_TOTAL=8, V_TOTAL=6.
  - `hs`=0 at x=5..6; `vs`=0 on y=4.
  - Frame = 48 `ce` cycles.
  - Reset asserted at x=3, y=2 → immediate return to x=7, y=5.
- **Frame counter:** with `VGA_TIMING_FRAME_CNT_EN`, FCW=2, small mode → `frame_cnt` reads 1,2,3,0,1 over five consecutive frames.
